// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side adapter.
// Holds the adapter state encoding, the default word width and the address-width helper.
package fifo_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int addr_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry FIFO-ordered register buffer. entry0 is always the head.
// A simultaneous push and pop keeps order and leaves occupancy unchanged.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int Width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [1:0]       occ,
    output logic [Width-1:0] head
);

    logic [Width-1:0] entry0;
    logic [Width-1:0] entry1;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            occ    <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        entry0 <= din;
                    end else begin
                        entry1 <= din;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    // The incoming word lands behind whatever remains after the head leaves.
                    if (occ == 2'd1) begin
                        entry0 <= din;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head = (occ != 2'd0) ? entry0 : '0;

endmodule

// File: rtl/fifo_read_adapter.sv
// Read-domain consumer of the async FIFO: pops words with 1-cycle read latency and
// re-presents them as a valid/ready stream through a skid buffer, with flush and a word counter.
module fifo_read_adapter
    import fifo_pkg::*;
#(
    parameter int Width = DEFAULT_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             r_rst,
    input  logic             fifo_empty,
    input  logic [Width-1:0] fifo_rdata,
    output logic             fifo_ren,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [Width-1:0] m_data,
    input  logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count
);

    state_t           state;
    state_t           state_next;
    logic             inflight;
    logic [1:0]       occ;
    logic [Width-1:0] head;
    logic             pop;
    logic             capture;
    logic             clear;
    logic [2:0]       level;

    assign pop     = m_valid && m_ready;
    assign capture = (state == RUN) && inflight;
    assign clear   = (state == RUN) && flush;
    assign m_valid = (occ != 2'd0) && (state == RUN);
    assign m_data  = head;
    assign busy    = (state == FLUSH);

    // Words already committed (held plus arriving) after this cycle's pop; a new pop
    // request is only safe while that stays below the buffer depth.
    assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    always_ff @(posedge rclk) begin
        if (r_rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fifo_ren   = 1'b0;
        case (state)
            RUN: begin
                fifo_ren = !r_rst && !fifo_empty && (level < 3'd2);
                if (flush) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                fifo_ren = !r_rst && !fifo_empty;
                if (fifo_empty && !inflight) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (r_rst) begin
            inflight <= 1'b0;
            rd_count <= '0;
        end else begin
            inflight <= fifo_ren;
            if (pop) begin
                rd_count <= rd_count + CNT_W'(1);
            end
        end
    end

    fifo_skid_buf #(
        .Width(Width)
    ) u_skid (
        .clk  (rclk),
        .rst  (r_rst),
        .clear(clear),
        .push (capture),
        .pop  (pop),
        .din  (fifo_rdata),
        .occ  (occ),
        .head (head)
    );

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Directed bench for fifo_read_adapter: a behavioural FIFO with 1-cycle read latency,
// a per-cycle vector table, an in-order scoreboard and hand-written corner sequences.
module tb_fifo_read_adapter;

    localparam int Width     = 4;
    localparam int CNT_W     = 16;
    localparam int MEM_DEPTH = 1024;
    localparam int NUM_VECS  = 17;

    logic             rclk = 1'b0;
    logic             r_rst;
    logic             fifo_empty;
    logic [Width-1:0] fifo_rdata = '0;
    logic             fifo_ren;
    logic             m_valid;
    logic             m_ready;
    logic [Width-1:0] m_data;
    logic             flush;
    logic             busy;
    logic [CNT_W-1:0] rd_count;

    logic [Width-1:0] fifo_mem [MEM_DEPTH];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    logic [Width-1:0] exp_q [$];
    logic [Width-1:0] sb_word;
    int               checks = 0;
    int               errors = 0;
    int               delivered = 0;
    int               burst_base;
    int               waited;
    int               wrap_words;

    typedef struct {
        int          push_n;
        logic [3:0]  push_base;
        logic        m_ready;
        logic        flush;
        logic        exp_ren;
        logic        exp_valid;
        logic [3:0]  exp_data;
        logic        exp_busy;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs [NUM_VECS];

    always #5 rclk = ~rclk;

    fifo_read_adapter #(
        .Width(Width),
        .CNT_W(CNT_W)
    ) dut (
        .rclk      (rclk),
        .r_rst     (r_rst),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_ren  (fifo_ren),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .flush     (flush),
        .busy      (busy),
        .rd_count  (rd_count)
    );

    // Behavioural FIFO read port; its read pointer resets together with the adapter.
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge rclk) begin
        if (r_rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_ren) begin
            fifo_rdata <= fifo_mem[rd_ptr % MEM_DEPTH];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    always @(negedge rclk) begin
        checks++;
        if (dut.occ > 2'd2) begin
            errors++;
            $display("[TB] FAIL occ_bound: occ=%0d, required <=2", dut.occ);
        end
        checks++;
        if (fifo_ren && fifo_empty) begin
            errors++;
            $display("[TB] FAIL ren_while_empty: fifo_ren=1 with fifo_empty=1, required no pop");
        end
        if (m_valid && m_ready) begin
            checks++;
            delivered++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_word: got 0x%0h, required no delivery", m_data);
            end else begin
                sb_word = exp_q.pop_front();
                if (m_data !== sb_word) begin
                    errors++;
                    $display("[TB] FAIL stream_order: got 0x%0h, required 0x%0h", m_data, sb_word);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic next_cycle();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_word(input logic [Width-1:0] d);
        fifo_mem[wr_ptr % MEM_DEPTH] = d;
        wr_ptr++;
        exp_q.push_back(d);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        for (int k = 0; k < v.push_n; k++) begin
            push_word(Width'(v.push_base + Width'(k)));
        end
        m_ready = v.m_ready;
        flush   = v.flush;
    endtask

    function automatic vec_t mk(input int pn, input logic [3:0] pb, input logic rdy,
                                input logic ren, input logic vld, input logic [3:0] dat,
                                input logic [15:0] cnt);
        vec_t v;
        v.push_n    = pn;
        v.push_base = pb;
        v.m_ready   = rdy;
        v.flush     = 1'b0;
        v.exp_ren   = ren;
        v.exp_valid = vld;
        v.exp_data  = dat;
        v.exp_busy  = 1'b0;
        v.exp_count = cnt;
        return v;
    endfunction

    initial begin
        // Preloaded 1,2,3 with ready high, then 1..4 queued against backpressure.
        vecs[0]  = mk(3, 4'h1, 1'b1, 1'b1, 1'b0, 4'h0, 16'd0);
        vecs[1]  = mk(0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 16'd0);
        vecs[2]  = mk(0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h1, 16'd0);
        vecs[3]  = mk(0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h2, 16'd1);
        vecs[4]  = mk(0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h3, 16'd2);
        vecs[5]  = mk(0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 16'd3);
        vecs[6]  = mk(0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 16'd3);
        vecs[7]  = mk(4, 4'h1, 1'b0, 1'b1, 1'b0, 4'h0, 16'd3);
        vecs[8]  = mk(0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 16'd3);
        vecs[9]  = mk(0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 16'd3);
        vecs[10] = mk(0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 16'd3);
        vecs[11] = mk(0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 16'd3);
        vecs[12] = mk(0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h1, 16'd3);
        vecs[13] = mk(0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h2, 16'd4);
        vecs[14] = mk(0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h3, 16'd5);
        vecs[15] = mk(0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h4, 16'd6);
        vecs[16] = mk(0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 16'd7);

        r_rst   = 1'b1;
        m_ready = 1'b0;
        flush   = 1'b0;
        repeat (3) next_cycle();
        @(negedge rclk);
        check_output("reset_state", 32'({fifo_ren, m_valid, m_data, busy, rd_count}), 32'd0);

        for (int i = 0; i < NUM_VECS; i++) begin
            next_cycle();
            r_rst = 1'b0;
            apply_stimulus(vecs[i]);
            @(negedge rclk);
            check_output($sformatf("vector%0d", i),
                         32'({fifo_ren, m_valid, m_data, busy, rd_count}),
                         32'({vecs[i].exp_ren, vecs[i].exp_valid, vecs[i].exp_data,
                              vecs[i].exp_busy, vecs[i].exp_count}));
            if (i == 11) begin
                check_output("occ_full", 32'(dut.occ), 32'd2);
            end
        end

        // 10-word burst under toggling ready.
        next_cycle();
        burst_base = delivered;
        for (int k = 0; k < 10; k++) begin
            push_word(Width'(k + 5));
        end
        m_ready = 1'b1;
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
            next_cycle();
            m_ready = (c % 2 == 1);
        end
        @(negedge rclk);
        check_output("burst_count", 32'(delivered - burst_base), 32'd10);
        check_output("burst_rd_count", 32'(rd_count), 32'd17);

        // Flush with a full buffer and three words still queued; the same-cycle pop counts.
        next_cycle();
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_word(Width'(k + 1));
        end
        repeat (4) next_cycle();
        @(negedge rclk);
        check_output("preflush_occ", 32'(dut.occ), 32'd2);
        check_output("preflush_queued", 32'(wr_ptr - rd_ptr), 32'd3);
        next_cycle();
        flush   = 1'b1;
        m_ready = 1'b1;
        next_cycle();
        flush = 1'b0;
        exp_q.delete();
        @(negedge rclk);
        check_output("flush_valid", 32'(m_valid), 32'd0);
        check_output("flush_busy", 32'(busy), 32'd1);
        check_output("flush_rd_count", 32'(rd_count), 32'd18);
        waited = 0;
        while (busy && waited < 20) begin
            next_cycle();
            waited++;
        end
        @(negedge rclk);
        check_output("flush_done", 32'(busy), 32'd0);
        check_output("flush_drained", 32'(fifo_empty), 32'd1);
        check_output("flush_keep_count", 32'(rd_count), 32'd18);
        next_cycle();
        push_word(4'hA);
        repeat (5) next_cycle();
        @(negedge rclk);
        check_output("post_flush_delivered", 32'(exp_q.size()), 32'd0);
        check_output("post_flush_count", 32'(rd_count), 32'd19);

        // Counter wrap: fill up to all-ones, then one more word.
        wrap_words = 65535 - 19;
        m_ready    = 1'b1;
        for (int k = 0; k < wrap_words; k++) begin
            next_cycle();
            push_word(Width'(k));
        end
        repeat (6) next_cycle();
        @(negedge rclk);
        check_output("count_max", 32'(rd_count), 32'h0000FFFF);
        check_output("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
        next_cycle();
        push_word(4'h7);
        repeat (5) next_cycle();
        @(negedge rclk);
        check_output("count_wrap", 32'(rd_count), 32'd0);

        // Reset while a popped word is in flight and one word is buffered.
        next_cycle();
        m_ready = 1'b0;
        push_word(4'h3);
        repeat (3) next_cycle();
        push_word(4'h9);
        @(negedge rclk);
        check_output("prereset_ren", 32'(fifo_ren), 32'd1);
        check_output("prereset_occ", 32'(dut.occ), 32'd1);
        next_cycle();
        r_rst = 1'b1;
        exp_q.delete();
        @(negedge rclk);
        check_output("reset_ren_forced", 32'(fifo_ren), 32'd0);
        next_cycle();
        r_rst = 1'b0;
        @(negedge rclk);
        check_output("postreset_state", 32'({fifo_ren, m_valid, m_data, busy, rd_count}), 32'd0);
        check_output("postreset_occ", 32'(dut.occ), 32'd0);
        m_ready = 1'b1;
        repeat (4) next_cycle();
        @(negedge rclk);
        check_output("postreset_idle", 32'({m_valid, rd_count}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_read_adapter.md
Name: fifo_read_adapter

Overview:
- Read-side consumer for the async FIFO, living entirely in the read clock domain.
- Drives the FIFO pop interface (empty/ren/rdata, 1-cycle read latency) and re-presents the data as a valid/ready stream.
- Uses a 2-entry skid buffer so the stream sustains one word per cycle under backpressure.
- Adds a flush command that discards buffered and queued words, and a delivered-word counter.

Parameters:
- Width, 4, data word width; must match the FIFO's Width.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- rclk  input  1  read-domain clock
- r_rst  input  1  reset
- fifo_empty  input  1  FIFO empty flag (already rclk-domain)
- fifo_rdata  input  Width  FIFO read data; valid the cycle after a cycle with fifo_ren=1
- fifo_ren  output  1  FIFO pop request
- m_valid  output  1  stream data valid
- m_ready  input  1  downstream ready
- m_data  output  Width  stream data
- flush  input  1  one-cycle pulse: discard all pending data
- busy  output  1  high while in FLUSH state
- rd_count  output  CNT_W  words delivered (m_valid&&m_ready), wraps modulo 2^CNT_W

Behaviour:
- Single clock rclk; reset r_rst is synchronous and active-high.
- Reset state:
  - fifo_ren=0, m_valid=0, m_data=0, busy=0, rd_count=0.
  - Buffer occupancy occ=0, inflight=0, state=RUN.
- State: occ (0..2) is the number of words held in the skid buffer. inflight is a 1-bit register equal to fifo_ren delayed by one cycle, meaning a word arrives on fifo_rdata this cycle.
- pop = m_valid && m_ready.
- fifo_ren (combinational, forced 0 while r_rst=1):
  - RUN: !fifo_empty && (occ + inflight - pop) < 2.
  - FLUSH: !fifo_empty.
- Capture: in RUN, when inflight=1, fifo_rdata is written into the buffer tail at the clock edge.
- Ordering:
  - Buffer is FIFO-ordered; m_data always shows the head entry.
  - Simultaneous pop and capture keep order, and occ is unchanged.
- Stream outputs:
  - m_valid = (occ != 0) && state==RUN.
  - m_data = head entry when occ != 0, else 0.
  - m_data must stay stable while m_valid && !m_ready.
- Latency:
  - fifo_empty falls in cycle N → fifo_ren=1 in N → word captured at the end of N+1 → m_valid=1 in N+2.
  - Sustained 1 word/cycle while m_ready=1 and the FIFO stays non-empty.
- Overflow: occ never exceeds 2; the fifo_ren condition guarantees it. Verification asserts occ<=2 always.
- FSM, RUN→FLUSH:
  - Taken on the flush pulse; clears occ to 0 at that edge.
  - A pop in the same cycle still counts (rd_count increments).
- FSM, FLUSH:
  - busy=1, m_valid=0.
  - fifo_ren pops whenever the FIFO is non-empty; arriving inflight words are discarded.
- FSM, FLUSH→RUN: when fifo_empty=1 and inflight=0 in the same cycle; busy falls the next cycle.
- flush asserted while already in FLUSH: no effect.
- rd_count:
  - Increments by 1 on each pop; wraps from 2^CNT_W-1 to 0.
  - Not cleared by flush, only by r_rst.
- Reset mid-transfer:
  - Any inflight word is dropped; all outputs return to reset values the next cycle.
  - The FIFO read pointer is reset by the same r_rst.
- fifo_ren with fifo_empty=1 never occurs; verification asserts this.

Decomposition:
- Shared package fifo_pkg holds:
  - The state typedef enum {RUN, FLUSH}.
  - Default Width=4 and the address-width function ($clog2(Width)), shared with the FIFO top.
- One natural sub-module, fifo_skid_buf: 2-entry register buffer with push/pop/occ/head.
- The FSM, fifo_ren logic and counter stay in fifo_read_adapter.

Test Plan:
- Reset, then FIFO preloaded with 0x1,0x2,0x3, m_ready=1 → fifo_ren high from cycle 0; m_data 0x1,0x2,0x3 on consecutive cycles starting cycle 2; rd_count=3; m_valid=0 after.
- 4 words queued, m_ready=0 → exactly 2 fifo_ren pulses, occ=2, m_data=0x1 held stable; raise m_ready → 0x1..0x4 in order, no gaps.
- m_ready toggling 1,0,1,0 over a 10-word burst → all 10 words delivered in order, no duplicates or drops; occ<=2 and no fifo_ren while empty, checked every cycle.
- occ=2 and 3 words still queued, pulse flush → m_valid=0 next cycle; busy=1; FIFO drained to empty; busy falls; rd_count unchanged; a new word 0xA is then delivered normally.
- rd_count preset by delivering 65535 words (CNT_W=16), then 1 more → rd_count=0.
- r_rst asserted the cycle after fifo_ren=1 with occ=1 → next cycle m_valid=0, occ=0, rd_count=0, inflight word discarded.
